// File: rtl/e203_tb_irq_stim.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | e203_tb_irq_stim : per-channel random interrupt stimulus + test counters |
// | Optional ASSERT timeout under macro E203_TB_IRQ_TIMEOUT_EN               |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module e203_tb_irq_stim #(
  parameter int          NCH      = 3,
  parameter int          PC_W     = 32,
  parameter int          DLY_W    = 10,
  parameter int          STOP_CNT = 32,
  parameter int          DONE_CNT = 8,
  parameter logic [15:0] SEED     = 16'hACE1,
  parameter int          TMO_CYC  = 4096
) (
  input  logic                hfclk,
  input  logic                rst_n,
  input  logic                cmt_valid,
  input  logic [PC_W-1:0]     cmt_pc,
  input  logic                exu_i_valid,
  input  logic                exu_i_ready,
  input  logic [PC_W-1:0]     start_pc,
  input  logic [PC_W-1:0]     tohost_pc,
  input  logic [NCH*PC_W-1:0] ack_pc,
  output logic [NCH-1:0]      irq,
  output logic [31:0]         cycle_cnt,
  output logic [31:0]         instret_cnt,
  output logic [31:0]         tohost_cnt,
  output logic [31:0]         tohost_cycle,
  output logic                done,
  output logic [NCH-1:0]      tmo_err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ASSERT = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  logic [31:0] r_cycle_cnt;
  logic [31:0] r_instret_cnt;
  logic [31:0] r_tohost_cnt;
  logic [31:0] r_tohost_cycle;
  logic        r_done;
  logic        w_tohost_hit;
  logic        w_arm;
  logic        w_stop;

  assign w_tohost_hit = cmt_valid & (cmt_pc == tohost_pc);
  assign w_arm        = cmt_valid & (cmt_pc == start_pc);
  assign w_stop       = r_tohost_cnt > 32'(STOP_CNT);

  always_ff @(posedge hfclk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle_cnt    <= '0;
      r_instret_cnt  <= '0;
      r_tohost_cnt   <= '0;
      r_tohost_cycle <= '0;
      r_done         <= 1'b0;
    end else begin
      r_cycle_cnt <= r_cycle_cnt + 32'd1;
      if (exu_i_valid && exu_i_ready && (r_tohost_cnt == '0))
        r_instret_cnt <= r_instret_cnt + 32'd1;
      if (w_tohost_hit) begin
        r_tohost_cnt <= r_tohost_cnt + 32'd1;
        if (r_tohost_cnt == '0)
          r_tohost_cycle <= r_cycle_cnt;
      end
      if ((r_tohost_cnt >= 32'(DONE_CNT)) && (irq == '0))
        r_done <= 1'b1;
    end
  end

  assign cycle_cnt    = r_cycle_cnt;
  assign instret_cnt  = r_instret_cnt;
  assign tohost_cnt   = r_tohost_cnt;
  assign tohost_cycle = r_tohost_cycle;
  assign done         = r_done;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    state_t         r_state;
    state_t         w_state_nxt;
    logic [15:0]    r_lfsr;
    logic [DLY_W:0] r_dly;
    logic [DLY_W:0] w_dly_nxt;
    logic [DLY_W:0] w_dly_load;
    logic           w_ack;
    logic           w_tmo;

    assign w_ack      = cmt_valid & (cmt_pc == ack_pc[gi*PC_W +: PC_W]);
    assign w_dly_load = {1'b0, r_lfsr[DLY_W-1:0]} + (DLY_W+1)'(1);

`ifdef E203_TB_IRQ_TIMEOUT_EN
    localparam int RES_W = $clog2(TMO_CYC + 1);
    logic [RES_W-1:0] r_res;
    logic             r_tmo;

    // Residency restarts whenever the channel is outside ASSERT.
    always_ff @(posedge hfclk or negedge rst_n) begin
      if (!rst_n) begin
        r_res <= '0;
        r_tmo <= 1'b0;
      end else if (r_state == S_ASSERT) begin
        if (w_tmo) begin
          r_res <= '0;
          r_tmo <= 1'b1;
        end else begin
          r_res <= r_res + RES_W'(1);
        end
      end else begin
        r_res <= '0;
      end
    end

    assign w_tmo       = (r_state == S_ASSERT) && (r_res == RES_W'(TMO_CYC - 1));
    assign tmo_err[gi] = r_tmo;
`else
    assign w_tmo = 1'b0;
`endif

    always_ff @(posedge hfclk or negedge rst_n) begin
      if (!rst_n) begin
        r_state <= S_IDLE;
        r_dly   <= '0;
        r_lfsr  <= SEED ^ 16'(gi);
      end else begin
        r_state <= w_state_nxt;
        r_dly   <= w_dly_nxt;
        r_lfsr  <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
      end
    end

    // Arm has priority over ack in IDLE simply because ack is not decoded there.
    always_comb begin
      w_state_nxt = r_state;
      w_dly_nxt   = r_dly;
      case (r_state)
        S_IDLE: begin
          if (w_arm) begin
            w_state_nxt = S_WAIT;
            w_dly_nxt   = w_dly_load;
          end
        end
        S_WAIT: begin
          if (w_stop)
            w_state_nxt = S_STOP;
          else if (r_dly == (DLY_W+1)'(1))
            w_state_nxt = S_ASSERT;
          else
            w_dly_nxt = r_dly - (DLY_W+1)'(1);
        end
        S_ASSERT: begin
          if (w_ack || w_tmo) begin
            if (w_stop) begin
              w_state_nxt = S_STOP;
            end else begin
              w_state_nxt = S_WAIT;
              w_dly_nxt   = w_dly_load;
            end
          end
        end
        S_STOP:  w_state_nxt = S_STOP;
        default: w_state_nxt = S_IDLE;
      endcase
    end

    assign irq[gi] = (r_state == S_ASSERT);
  end

`ifndef E203_TB_IRQ_TIMEOUT_EN
  if (TMO_CYC > 0) begin : g_tmo_off
    assign tmo_err = '0;
  end else begin : g_tmo_off_z
    assign tmo_err = '0;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_e203_tb_irq_stim.sv
`default_nettype none
// Randomised bench for e203_tb_irq_stim against a timestamp-based reference model.
module tb_e203_tb_irq_stim;
  localparam int          NCH      = 3;
  localparam int          PC_W     = 32;
  localparam int          DLY_W    = 4;
  localparam int          STOP_CNT = 2;
  localparam int          DONE_CNT = 8;
  localparam int          TMO_CYC  = 50;
  localparam logic [15:0] SEED     = 16'hACE1;
  localparam logic [31:0] START_PC  = 32'h8000_0100;
  localparam logic [31:0] TOHOST_PC = 32'h8000_0200;

  logic                hfclk = 1'b0;
  logic                rst_n = 1'b0;
  logic                cmt_valid = 1'b0;
  logic [PC_W-1:0]     cmt_pc = '0;
  logic                exu_i_valid = 1'b0;
  logic                exu_i_ready = 1'b0;
  logic [PC_W-1:0]     start_pc = START_PC;
  logic [PC_W-1:0]     tohost_pc = TOHOST_PC;
  logic [NCH*PC_W-1:0] ack_pc = '0;
  logic [NCH-1:0]      irq;
  logic [31:0]         cycle_cnt, instret_cnt, tohost_cnt, tohost_cycle;
  logic                done;
  logic [NCH-1:0]      tmo_err;

  e203_tb_irq_stim #(
    .NCH(NCH), .PC_W(PC_W), .DLY_W(DLY_W), .STOP_CNT(STOP_CNT),
    .DONE_CNT(DONE_CNT), .SEED(SEED), .TMO_CYC(TMO_CYC)
  ) u_dut (
    .hfclk(hfclk), .rst_n(rst_n), .cmt_valid(cmt_valid), .cmt_pc(cmt_pc),
    .exu_i_valid(exu_i_valid), .exu_i_ready(exu_i_ready), .start_pc(start_pc),
    .tohost_pc(tohost_pc), .ack_pc(ack_pc), .irq(irq), .cycle_cnt(cycle_cnt),
    .instret_cnt(instret_cnt), .tohost_cnt(tohost_cnt), .tohost_cycle(tohost_cycle),
    .done(done), .tmo_err(tmo_err)
  );

  always #5 hfclk = ~hfclk;

  int unsigned n_err = 0;
  int unsigned n_chk = 0;

  // Reference model: waits are tracked as absolute fire times, not down-counters.
  logic [31:0]    m_cyc, m_instret, m_tohost, m_tohost_cycle;
  logic           m_done;
  logic [15:0]    m_lfsr [NCH];
  int             m_ph [NCH];      // 0 unarmed, 1 waiting, 2 firing, 3 retired
  logic [31:0]    m_fire_at [NCH];
  logic [31:0]    m_on_at [NCH];
  logic [NCH-1:0] m_tmo;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ack_of(input int i);
    return ack_pc[i*PC_W +: PC_W];
  endfunction

  function automatic logic [NCH-1:0] model_irq();
    logic [NCH-1:0] v = '0;
    for (int i = 0; i < NCH; i++) v[i] = (m_ph[i] == 2);
    return v;
  endfunction

  task automatic model_reset();
    m_cyc = 0; m_instret = 0; m_tohost = 0; m_tohost_cycle = 0; m_done = 0; m_tmo = '0;
    for (int i = 0; i < NCH; i++) begin
      m_lfsr[i] = SEED ^ 16'(i);
      m_ph[i] = 0; m_fire_at[i] = 0; m_on_at[i] = 0;
    end
  endtask

  task automatic model_edge();
    logic [31:0]    e, d;
    logic           stop, ack, tmo;
    logic [NCH-1:0] irq_pre;
    e       = m_cyc + 32'd1;
    stop    = m_tohost > STOP_CNT;
    irq_pre = model_irq();
    for (int i = 0; i < NCH; i++) begin
      ack = cmt_valid && (cmt_pc == ack_of(i));
      d   = (32'(m_lfsr[i]) % (32'd1 << DLY_W)) + 32'd1;
`ifdef E203_TB_IRQ_TIMEOUT_EN
      tmo = (m_ph[i] == 2) && (e == m_on_at[i] + TMO_CYC);
`else
      tmo = 1'b0;
`endif
      case (m_ph[i])
        0: if (cmt_valid && cmt_pc == START_PC) begin m_ph[i] = 1; m_fire_at[i] = e + d; end
        1: if (stop) m_ph[i] = 3;
           else if (e == m_fire_at[i]) begin m_ph[i] = 2; m_on_at[i] = e; end
        2: if (ack || tmo) begin
             if (tmo) m_tmo[i] = 1'b1;
             if (stop) m_ph[i] = 3;
             else begin m_ph[i] = 1; m_fire_at[i] = e + d; end
           end
        default: ;
      endcase
      m_lfsr[i] = (m_lfsr[i] >> 1) ^ (m_lfsr[i][0] ? 16'hB400 : 16'h0000);
    end
    if (m_tohost >= DONE_CNT && irq_pre == '0) m_done = 1'b1;
    if (exu_i_valid && exu_i_ready && m_tohost == 0) m_instret++;
    if (cmt_valid && cmt_pc == TOHOST_PC) begin
      if (m_tohost == 0) m_tohost_cycle = m_cyc;
      m_tohost++;
    end
    m_cyc = e;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".irq"}, 32'(irq), 32'(model_irq()));
    check({tag, ".tmo"}, 32'(tmo_err), 32'(m_tmo));
    check({tag, ".done"}, 32'(done), 32'(m_done));
    check({tag, ".cyc"}, cycle_cnt, m_cyc);
    check({tag, ".instret"}, instret_cnt, m_instret);
    check({tag, ".tohost"}, tohost_cnt, m_tohost);
    check({tag, ".tocyc"}, tohost_cycle, m_tohost_cycle);
  endtask

  task automatic tick();
    @(posedge hfclk);
    model_edge();
    #1;
    compare_all("cyc");
    exu_i_valid = 1'($urandom_range(0, 1));
    exu_i_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic set_cmt(input logic v, input logic [31:0] pc);
    cmt_valid = v;
    cmt_pc    = pc;
  endtask

  task automatic rand_cmt(input bit allow_tohost);
    int r = $urandom_range(0, 12);
    if (r <= 5)       set_cmt(1'b0, 32'h0);
    else if (r == 6)  set_cmt(1'b1, START_PC);
    else if (r <= 9)  set_cmt(1'b1, ack_of($urandom_range(0, NCH - 1)));
    else if (r == 10) set_cmt(1'b1, 32'h8000_0F00 + 32'($urandom_range(0, 255)));
    else if (r == 11) set_cmt(1'b0, ack_of($urandom_range(0, NCH - 1)));
    else              set_cmt(allow_tohost, allow_tohost ? TOHOST_PC : START_PC);
  endtask

  task automatic do_reset();
    set_cmt(1'b0, 32'h0);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_irq", 32'(irq), 32'h0);
    model_reset();
    compare_all("rst");
    @(posedge hfclk);
    @(posedge hfclk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_irq(input logic [NCH-1:0] mask, input int bound, input string tag);
    int n = 0;
    while (((irq & mask) != mask) && n < bound) begin
      tick();
      n++;
    end
    check(tag, 32'(irq & mask), 32'(mask));
  endtask

  task automatic arm();
    set_cmt(1'b1, START_PC);
    tick();
    set_cmt(1'b0, 32'h0);
  endtask

  logic [31:0] first_hit;
  bit          seen_irq0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NCH; i++) ack_pc[i*PC_W +: PC_W] = 32'h8000_0310 + 32'(i) * 32'h10;
    model_reset();
    repeat (3) @(posedge hfclk);
    #1;
    compare_all("rst0");
    rst_n = 1'b1;

    // Idle run: only the cycle/instret counters move.
    repeat (100) tick();
    check("cyc100", cycle_cnt, 32'd100);
    check("idle_irq", 32'(irq), 32'h0);

    arm();
    wait_irq(3'b111, 40, "all_irq_run1");
    do_reset();

    repeat (100) tick();
    arm();
    wait_irq(3'b111, 40, "all_irq_run2");

    set_cmt(1'b1, ack_of(1));
    tick();
    set_cmt(1'b0, 32'h0);
    check("ack1_only", 32'(irq), 32'b101);

    for (int n = 0; n < 300; n++) begin
      rand_cmt(1'b0);
      tick();
    end
    set_cmt(1'b0, 32'h0);

    wait_irq(3'b001, 80, "irq0_before_stop");
    for (int n = 0; n < 3; n++) begin
      if (n == 0) first_hit = m_cyc;
      set_cmt(1'b1, TOHOST_PC);
      tick();
    end
    set_cmt(1'b1, ack_of(0));
    tick();
    check("irq0_stopped", 32'(irq[0]), 32'h0);
    seen_irq0 = 1'b0;
    for (int n = 0; n < 100; n++) begin
      rand_cmt(1'b0);
      tick();
      if (irq[0]) seen_irq0 = 1'b1;
    end
    check("irq0_never_again", 32'(seen_irq0), 32'h0);

    for (int n = 0; n < DONE_CNT - 3; n++) begin
      set_cmt(1'b1, TOHOST_PC);
      tick();
    end
    for (int n = 0; n < 60 && irq != '0; n++) begin
      logic [31:0] pc = 32'h0;
      for (int i = NCH - 1; i >= 0; i--) if (irq[i]) pc = ack_of(i);
      set_cmt(1'b1, pc);
      tick();
    end
    set_cmt(1'b0, 32'h0);
    tick();
    tick();
    check("irq_quiet", 32'(irq), 32'h0);
    check("done_set", 32'(done), 32'h1);
    check("tohost_cnt8", tohost_cnt, 32'(DONE_CNT));
    check("tohost_cycle", tohost_cycle, first_hit);
    for (int n = 0; n < 20; n++) begin
      rand_cmt(1'b1);
      tick();
    end
    check("done_sticky", 32'(done), 32'h1);

    do_reset();
    arm();
    wait_irq(3'b100, 40, "irq2_up");
    repeat (TMO_CYC) tick();
`ifdef E203_TB_IRQ_TIMEOUT_EN
    check("tmo_irq2", 32'(irq[2]), 32'h0);
    check("tmo_err2", 32'(tmo_err[2]), 32'h1);
`else
    check("tmo_irq2", 32'(irq[2]), 32'h1);
    check("tmo_err2", 32'(tmo_err), 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
